pg_param_loader: RTL and testbench

//  Command-side driver for profile_gen's parameter port and acc_step input. Buffers 64-bit parameter

---
 rtl/pg_param_loader.sv | 179 +++++++++++++++++
 tb/tb_pg_param_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pg_param_loader.sv
// pg_param_loader
//   Drives profile_gen's parameter port and its acc_step input. Incoming
//   64-bit parameter commands are buffered in a FIFO. Each command is then
//   sent as registered 32-bit lo/hi write beats. A periodic acc_step tick is
//   held back while any write is in flight, so profile_gen never steps on a
//   parameter that is only half written.
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready = !full)
//   cmd_addr/cmd_data/cmd_mode    8-bit address, 64-bit value, beat mode
//                                 (00 lo+hi, 01 lo, 10 hi, 11 fill)
//   step_en/step_div              tick enable; tick period is step_div+1
//   param_addr/param_in           registered write address and data
//   param_write_lo/_hi            registered write strobes
//   acc_step                      one-cycle step pulse
//   busy                          FIFO non-empty or writer active
//   fifo_level                    FIFO occupancy, 0..FIFO_DEPTH
//   step_overrun                  sticky: a tick landed on a pending one
module pg_param_loader #(
  parameter int FIFO_DEPTH = 8,
  parameter int STEP_DIV_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_addr,
  input  logic [63:0]                   cmd_data,
  input  logic [1:0]                    cmd_mode,
  input  logic                          step_en,
  input  logic [STEP_DIV_W-1:0]         step_div,
  output logic [7:0]                    param_addr,
  output logic [31:0]                   param_in,
  output logic                          param_write_lo,
  output logic                          param_write_hi,
  output logic                          acc_step,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          step_overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  // FIFO: pointers carry one extra wrap bit so the difference is the level.
  logic [73:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          full, empty, push, pop;
  logic [73:0]   head;

  assign fifo_level = wptr_q - rptr_q;
  assign full       = (fifo_level == FIFO_DEPTH[AW:0]);
  assign empty      = (fifo_level == '0);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign head       = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {cmd_mode, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Writer. The state says which beat to drive. The beat is registered onto
  // param_* one cycle later, which gives the two-cycle accept-to-strobe
  // latency.
  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    addr_q, addr_d;
  logic [63:0]   data_q, data_d;
  logic          last_beat;
  logic [7:0]    paddr_q, paddr_d;
  logic [31:0]   pin_q, pin_d;
  logic          wlo_q, wlo_d, whi_q, whi_d;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    data_d    = data_q;
    paddr_d   = '0;
    pin_d     = '0;
    wlo_d     = 1'b0;
    whi_d     = 1'b0;
    last_beat = (state_q == WR_HI) || (state_q == WR_LO && mode_q != 2'b00);
    // Popping on the last beat keeps back-to-back commands free of bubbles.
    pop       = (state_q == IDLE || last_beat) && !empty;
    if (pop) begin
      {mode_d, addr_d, data_d} = head;
      state_d = (head[73:72] == 2'b10) ? WR_HI : WR_LO;
    end else if (state_q == WR_LO && mode_q == 2'b00) begin
      state_d = WR_HI;
    end else if (last_beat) begin
      state_d = IDLE;
    end
    case (state_q)
      WR_LO: begin
        paddr_d = addr_q;
        pin_d   = data_q[31:0];
        wlo_d   = 1'b1;
        whi_d   = (mode_q == 2'b11);   // fill writes both halves
      end
      WR_HI: begin
        paddr_d = addr_q;
        pin_d   = data_q[63:32];
        whi_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      paddr_q <= '0;
      pin_q   <= '0;
      wlo_q   <= 1'b0;
      whi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      paddr_q <= paddr_d;
      pin_q   <= pin_d;
      wlo_q   <= wlo_d;
      whi_q   <= whi_d;
    end
  end

  assign param_addr     = paddr_q;
  assign param_in       = pin_q;
  assign param_write_lo = wlo_q;
  assign param_write_hi = whi_q;
  assign busy           = !empty || (state_q != IDLE);

  // Step generator. The compare is >= so that lowering step_div below the
  // current count wraps the counter at once.
  logic [STEP_DIV_W-1:0] cnt_q, cnt_d;
  logic                  pend_q, pend_d, ovr_q, ovr_d, tick, fire;

  always_comb begin
    tick   = step_en && (cnt_q >= step_div);
    // The registered strobe lags busy by one cycle, so both must be quiet.
    fire   = pend_q && !busy && !wlo_q && !whi_q;
    cnt_d  = (!step_en || tick) ? '0 : cnt_q + 1'b1;
    pend_d = pend_q;
    if (!step_en)  pend_d = 1'b0;
    else if (tick) pend_d = 1'b1;   // a tick in the fire cycle re-arms
    else if (fire) pend_d = 1'b0;
    ovr_d  = ovr_q | (tick && pend_q && !fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign acc_step     = fire;
  assign step_overrun = ovr_q;
endmodule

// File: tb/tb_pg_param_loader.sv
module tb_pg_param_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic [1:0]  cmd_mode = '0;
  logic        step_en = 1'b0;
  logic [15:0] step_div = '0;
  logic [7:0]  param_addr;
  logic [31:0] param_in;
  logic        param_write_lo, param_write_hi, acc_step, busy, step_overrun;
  logic [3:0]  fifo_level;

  pg_param_loader #(.FIFO_DEPTH(8), .STEP_DIV_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mode(cmd_mode),
    .step_en(step_en), .step_div(step_div), .param_addr(param_addr),
    .param_in(param_in), .param_write_lo(param_write_lo),
    .param_write_hi(param_write_hi), .acc_step(acc_step), .busy(busy),
    .fifo_level(fifo_level), .step_overrun(step_overrun));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [31:0] d; logic lo; logic hi; } beat_t;
  beat_t exp_q[$];
  int    beat_cyc[$];
  int    step_cyc[$];
  int    nvec = 0, nerr = 0, cyc = 0, peak = 0;
  bit    saw_nr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe cycle.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
    if (!cmd_ready) saw_nr = 1;
    if (param_write_lo || param_write_hi) begin
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("beat", {param_addr, param_in, param_write_lo, param_write_hi},
                    {e.a, e.d, e.lo, e.hi});
      end
    end else begin
      chk("idle_zero", {param_addr, param_in}, 64'd0);
    end
    if (acc_step) begin
      step_cyc.push_back(cyc);
      chk("step_alongside_write", {busy, param_write_lo, param_write_hi}, 64'd0);
    end
  end

  task automatic push(input logic [7:0] a, input logic [63:0] d, input logic [1:0] m);
    bit r;
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_mode = m;
    forever begin
      r = cmd_ready;
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 100) begin chk("push_timeout", 64'd1, 64'd0); break; end
      @(negedge clk);
    end
    case (m)
      2'b00: begin
        exp_q.push_back('{a, d[31:0], 1'b1, 1'b0});
        exp_q.push_back('{a, d[63:32], 1'b0, 1'b1});
      end
      2'b01: exp_q.push_back('{a, d[31:0], 1'b1, 1'b0});
      2'b10: exp_q.push_back('{a, d[63:32], 1'b0, 1'b1});
      default: exp_q.push_back('{a, d[31:0], 1'b1, 1'b1});
    endcase
  endtask

  task automatic idle_in();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 500);
    chk("wait_idle_timeout", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {param_write_lo, param_write_hi, acc_step, busy, step_overrun}, 64'd0);
    chk("rst_param", {param_addr, param_in}, 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_level", 64'(fifo_level), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 2: lo/hi latency and data
    push(8'd3, 64'hFFFFFFFF_FFFFFED4, 2'b00);
    idle_in();
    chk("t2_e1_nostrobe", {param_write_lo, param_write_hi}, 64'd0);
    @(negedge clk);
    chk("t2_e2_nostrobe", {param_write_lo, param_write_hi}, 64'd0);
    @(negedge clk);
    chk("t2_lo", {param_addr, param_in, param_write_lo, param_write_hi},
                 {8'd3, 32'hFFFFFED4, 1'b1, 1'b0});
    @(negedge clk);
    chk("t2_hi", {param_addr, param_in, param_write_lo, param_write_hi},
                 {8'd3, 32'hFFFFFFFF, 1'b0, 1'b1});
    @(negedge clk);
    chk("t2_done", {param_write_lo, param_write_hi}, 64'd0);
    wait_idle();

    // 3: fill, lo-only, hi-only
    push(8'h20, 64'd0, 2'b11);
    push(8'h00, 64'd3, 2'b01);
    push(8'h41, 64'hCAFEBABE_00000000, 2'b10);
    idle_in();
    wait_idle();

    // 4: burst deep enough to fill the FIFO
    beat_cyc.delete(); peak = 0; saw_nr = 0;
    for (int i = 0; i < 20; i++)
      push(8'(i), {32'hA000_0000 | 32'(i), 32'h5000_0000 | 32'(i)}, 2'b00);
    idle_in();
    wait_idle();
    chk("t4_beats", 64'(beat_cyc.size()), 64'd40);
    if (beat_cyc.size() == 40) chk("t4_no_bubbles", 64'(beat_cyc[39] - beat_cyc[0]), 64'd39);
    chk("t4_peak", 64'(peak), 64'd8);
    chk("t4_ready_dropped", 64'(saw_nr), 64'd1);

    // 5: idle ticking
    @(negedge clk);
    step_div = 16'd99; step_en = 1'b1; step_cyc.delete();
    repeat (350) @(negedge clk);
    chk("t5_pulses", 64'(step_cyc.size()), 64'd3);
    if (step_cyc.size() == 3) begin
      chk("t5_period_a", 64'(step_cyc[1] - step_cyc[0]), 64'd100);
      chk("t5_period_b", 64'(step_cyc[2] - step_cyc[1]), 64'd100);
    end
    chk("t5_overrun", 64'(step_overrun), 64'd0);
    step_en = 1'b0;
    repeat (3) @(negedge clk);

    // 6: ticks deferred by a burst
    step_div = 16'd9; step_en = 1'b1; beat_cyc.delete(); step_cyc.delete();
    for (int i = 0; i < 14; i++)
      push(8'(8'h80 + i), {32'h1234_0000 | 32'(i), 32'h9876_0000 | 32'(i)}, 2'b00);
    idle_in();
    n = 0;
    while (!acc_step && n < 300) begin @(negedge clk); n++; end
    step_en = 1'b0;
    chk("t6_step_seen", 64'(acc_step), 64'd1);
    repeat (3) @(negedge clk);
    chk("t6_single_pulse", 64'(step_cyc.size()), 64'd1);
    if (step_cyc.size() == 1 && beat_cyc.size() == 28)
      chk("t6_after_last_beat", 64'(step_cyc[0] - beat_cyc[27]), 64'd1);
    chk("t6_overrun", 64'(step_overrun), 64'd1);
    wait_idle();

    // 7: reset between lo and hi beats
    push(8'd5, 64'h11112222_33334444, 2'b00);
    idle_in();
    n = 0;
    while (!param_write_lo && n < 20) begin @(negedge clk); n++; end
    chk("t7_lo_seen", 64'(param_write_lo), 64'd1);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t7_no_hi", {param_write_lo, param_write_hi, acc_step}, 64'd0);
    chk("t7_level", 64'(fifo_level), 64'd0);
    chk("t7_overrun_cleared", 64'(step_overrun), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t7_still_idle", {busy, param_write_lo, param_write_hi, acc_step}, 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
